acc_diff: RTL and testbench
===========================

Name: acc_diff

Overview:
- Inverse of the running-sum accumulator datapath: takes the stream of accumulated totals and recovers the per-sample increments.
  - out[n] = in[n] - in[n-1] mod 2^DATA_W.
  - For the first sample, in[-1] = 0, matching an accumulator reset to 0.
- Sits downstream of an accumulator (or across a link carrying its totals) with valid/ready handshakes on both sides.
- Used to check accumulator output or to reconstruct the original sample stream.

Parameters:
- DATA_W, 8, width of input totals and output differences.

Ports:
- clk_sys  input  1  system clock; all logic on rising edge.
- rst_sys  input  1  synchronous reset, active-high.
- clear  input  1  synchronous restart: next accepted sample is treated as first; pending output preserved.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept in_data this cycle.
- in_data  input  DATA_W  accumulated total.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  DATA_W  recovered increment.
- out_first  output  1  out_data belongs to the first sample after reset/clear.

Behaviour:
- Reset (rst_sys=1 at clock edge):
  - out_valid=0, out_data=0, out_first=0.
  - prev=0, state=IDLE.
  - Any held output is dropped.
  - in_ready is 0 during the reset cycle.
- Accept: in_valid && in_ready at a clock edge.
  - Consume: out_valid && out_ready.
- State machine (prev-sample tracking):
  - IDLE: no reference sample. On accept:
    - out_data <= in_data (in_data - 0), out_first <= 1.
    - prev <= in_data, go to PRIMED.
  - PRIMED: on accept:
    - out_data <= in_data - prev, truncated to DATA_W (modulo wrap, no saturation).
    - out_first <= 0, prev <= in_data.
  - clear=1: state <= IDLE and prev <= 0 at that edge.
    - If an accept occurs in the same cycle, that sample is treated as first: out_data=in_data, out_first=1, state ends in PRIMED.
- Output register: one pipeline stage, latency 1 cycle from accept to out_valid.
- Base handshake: in_ready = !out_valid || out_ready (combinational pass-through of out_ready).
  - Simultaneous consume and accept: new result loaded, out_valid stays 1, no bubble.
  - Consume without accept: out_valid <= 0.
  - Stall (out_valid && !out_ready): out_data and out_first held stable; in_ready=0.
- prev updates only on accept, never on stall.
- Full throughput: one result per cycle when out_ready held high.

Optional Feature:
- Macro: ACC_DIFF_SKID_EN.
- Defined: a 1-entry skid buffer (sub-module acc_diff_skid) is inserted between the input and the difference stage.
  - in_ready becomes a registered signal: in_ready = skid entry empty; no combinational path from out_ready to in_ready.
  - Latency is 1 cycle when the skid is empty, 2 cycles when a word was skidded.
  - Throughput stays 1/cycle.
  - Reset empties the skid.
  - clear applies to the next sample entering the difference stage; a word already skidded when clear is asserted is treated as first.
- Undefined: base combinational-ready behaviour above; no skid storage.

Decomposition:
- Package acc_diff_pkg:
  - DATA_W default constant.
  - typedef enum logic {IDLE, PRIMED} diff_state_t.
  - typedef logic [DATA_W-1:0] diff_word_t.
- Sub-module acc_diff_skid (generic 1-entry valid/ready skid buffer, DATA_W wide), instantiated only under ACC_DIFF_SKID_EN.
- Difference logic stays in acc_diff.

Test Plan:
- Wrap-around: after reset, send 3, 8, 8, 5 back-to-back with out_ready=1 -> out_data 3, 5, 0, 253 one cycle after each input; out_first=1 only on the 3.
- Wrap-around across zero: send 250, 4 -> 250, 10.
- Backpressure: send 10, 30 with out_ready=0 for 3 cycles after the first result.
  - Required: out_data=10 held stable, in_ready=0, prev unchanged.
  - After release: 10 then 20, no data lost or duplicated.
- Clear: stream 10, 15, then clear together with input 40 -> outputs 10, 5, 40 with out_first=1 on 40; next input 41 -> 1.
- Reset mid-stream: reset while out_valid=1 holding 7.
  - Required: out_valid=0, out_data=0 the cycle after.
  - Next input 9 -> 9 with out_first=1.
- ACC_DIFF_SKID_EN build: random out_ready toggling over 200 sums of a random increment stream.
  - Required: recovered increments equal the originals; in_ready never combinationally dependent on out_ready.

Source files
------------

// File: rtl/acc_diff_pkg.sv
// Shared types and constants for the accumulator-difference block.
package acc_diff_pkg;

    localparam int unsigned DATA_W = 8;

    // Whether a reference (previous) total is held for differencing.
    typedef enum logic {
        IDLE   = 1'b0,
        PRIMED = 1'b1
    } diff_state_t;

    typedef logic [DATA_W-1:0] diff_word_t;

endpackage

// File: rtl/acc_diff_skid.sv
// Generic 1-entry valid/ready skid buffer. in_ready is a register output,
// so there is no combinational path from out_ready back to in_ready.
module acc_diff_skid #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid_c,
    input  logic         out_ready,
    output logic [W-1:0] out_data_c
);

    logic         empty_q;
    logic         empty_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    assign in_ready    = empty_q;
    assign out_valid_c = !empty_q || in_valid;
    assign out_data_c  = empty_q ? in_data : data_q;

    // Capture an incoming word when downstream stalls; drain when it frees up.
    always_comb begin
        empty_d = empty_q;
        data_d  = data_q;
        if (empty_q) begin
            if (in_valid && !out_ready) begin
                data_d  = in_data;
                empty_d = 1'b0;
            end
        end else if (out_ready) begin
            empty_d = 1'b1;
        end
    end

    // Skid storage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            empty_q <= 1'b1;
            data_q  <= '0;
        end else begin
            empty_q <= empty_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/acc_diff.sv
// Recovers per-sample increments from a stream of accumulated totals:
// out[n] = in[n] - in[n-1] (mod 2^DATA_W), with in[-1] = 0.
// Optional macro ACC_DIFF_SKID_EN inserts a 1-entry skid buffer so that
// in_ready is registered instead of a pass-through of out_ready.
module acc_diff
    import acc_diff_pkg::*;
#(
    parameter int unsigned DATA_W = acc_diff_pkg::DATA_W
) (
    input  logic              clk_sys,
    input  logic              rst_sys,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_first
);

    // Difference-stage input side (either raw input or skid output).
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              accept;

    diff_state_t       state_q;
    diff_state_t       state_d;
    diff_state_t       cur_state;
    logic [DATA_W-1:0] prev_q;
    logic [DATA_W-1:0] prev_d;
    logic              out_valid_q;
    logic              out_valid_d;
    logic [DATA_W-1:0] out_data_q;
    logic [DATA_W-1:0] out_data_d;
    logic              out_first_q;
    logic              out_first_d;

    // The output register can take a new word when empty or being drained.
    assign s_ready = !out_valid_q || out_ready;
    assign accept  = s_valid && s_ready;

`ifdef ACC_DIFF_SKID_EN
    logic skid_in_ready;

    acc_diff_skid #(
        .W (DATA_W)
    ) u_skid (
        .clk         (clk_sys),
        .rst         (rst_sys),
        .in_valid    (in_valid),
        .in_ready    (skid_in_ready),
        .in_data     (in_data),
        .out_valid_c (s_valid),
        .out_ready   (s_ready),
        .out_data_c  (s_data)
    );

    assign in_ready = skid_in_ready && !rst_sys;
`else
    assign s_valid  = in_valid;
    assign s_data   = in_data;
    assign in_ready = s_ready && !rst_sys;
`endif

    // Next-state, reference tracking and output register load.
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_first_d = out_first_q;
        cur_state   = state_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // A clear in the same cycle as an accept makes that sample the first.
        if (clear) begin
            cur_state = IDLE;
            state_d   = IDLE;
            prev_d    = '0;
        end

        if (accept) begin
            out_valid_d = 1'b1;
            prev_d      = s_data;
            state_d     = PRIMED;
            case (cur_state)
                IDLE: begin
                    out_data_d  = s_data;
                    out_first_d = 1'b1;
                end
                PRIMED: begin
                    out_data_d  = DATA_W'(s_data - prev_q);
                    out_first_d = 1'b0;
                end
                default: begin
                    out_data_d  = s_data;
                    out_first_d = 1'b1;
                end
            endcase
        end
    end

    // State, reference and output registers.
    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            state_q     <= IDLE;
            prev_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_first_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_first_q <= out_first_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_first = out_first_q;

endmodule

// File: tb/tb_acc_diff.sv
// Self-checking bench for acc_diff: directed scenarios plus a randomized
// accumulated-stream run checked against a queue-based reference.
module tb_acc_diff;
    import acc_diff_pkg::*;

    localparam int unsigned N_RND = 200;

    logic       clk_sys = 1'b0;
    logic       rst_sys = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    diff_word_t in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    diff_word_t out_data;
    logic       out_first;

    acc_diff dut (
        .clk_sys   (clk_sys),
        .rst_sys   (rst_sys),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_first (out_first)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        diff_word_t d;
        logic       f;
    } exp_t;

    int n_checks = 0;
    int n_errors = 0;

    exp_t       exp_q[$];
    logic       m_first = 1'b1;
    diff_word_t m_prev = '0;
    logic       rnd_phase = 1'b0;
    int         rd_idx = 0;
    diff_word_t inc_arr[N_RND];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
        end
    endtask

    // Reference model and scoreboard, sampled on the falling edge.
    always @(negedge clk_sys) begin
        exp_t e;
        if (rst_sys) begin
            exp_q.delete();
            m_first = 1'b1;
            m_prev  = '0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_spurious", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_data", 32'(out_data), 32'(e.d));
                    check("sb_first", 32'(out_first), 32'(e.f));
                end
                if (rnd_phase) begin
                    if (rd_idx < N_RND) check("incr", 32'(out_data), 32'(inc_arr[rd_idx]));
                    else check("incr_extra", 1, 0);
                    rd_idx++;
                end
            end
            if (in_valid && in_ready) begin
                if (clear || m_first) e = '{d: in_data, f: 1'b1};
                else e = '{d: diff_word_t'(in_data - m_prev), f: 1'b0};
                exp_q.push_back(e);
                m_prev  = in_data;
                m_first = 1'b0;
            end else if (clear) begin
                m_first = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        rst_sys   = 1'b1;
        in_valid  = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 0);
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_first", 32'(out_first), 0);
        rst_sys = 1'b0;
    endtask

    task automatic push_chk(input diff_word_t d, input logic cl, input diff_word_t ed, input logic ef);
        in_valid = 1'b1;
        in_data  = d;
        clear    = cl;
        step();
        check("push_valid", 32'(out_valid), 1);
        check("push_data", 32'(out_data), 32'(ed));
        check("push_first", 32'(out_first), 32'(ef));
        clear = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        clear    = 1'b0;
        step();
    endtask

    initial begin
        diff_word_t total;
        logic       accepted;
        int         budget;
`ifdef ACC_DIFF_SKID_EN
        logic       r0;
`endif

        // Wrap-around within a stream.
        do_reset();
        push_chk(8'd3, 1'b0, 8'd3, 1'b1);
        push_chk(8'd8, 1'b0, 8'd5, 1'b0);
        push_chk(8'd8, 1'b0, 8'd0, 1'b0);
        push_chk(8'd5, 1'b0, 8'd253, 1'b0);
        idle();
        check("drain_valid", 32'(out_valid), 0);

        // Wrap across zero.
        do_reset();
        push_chk(8'd250, 1'b0, 8'd250, 1'b1);
        push_chk(8'd4, 1'b0, 8'd10, 1'b0);
        idle();

        // Backpressure hold.
        do_reset();
        push_chk(8'd10, 1'b0, 8'd10, 1'b1);
        in_data   = 8'd30;
        out_ready = 1'b0;
        #1;
`ifndef ACC_DIFF_SKID_EN
        check("stall_in_ready", 32'(in_ready), 0);
`endif
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_valid", 32'(out_valid), 1);
            check("stall_data", 32'(out_data), 10);
            check("stall_first", 32'(out_first), 1);
        end
        out_ready = 1'b1;
        step();
        check("release_valid", 32'(out_valid), 1);
        check("release_data", 32'(out_data), 20);
        check("release_first", 32'(out_first), 0);
        idle();
        check("release_drain", 32'(out_valid), 0);

        // Clear restarts the reference.
        do_reset();
        push_chk(8'd10, 1'b0, 8'd10, 1'b1);
        push_chk(8'd15, 1'b0, 8'd5, 1'b0);
        push_chk(8'd40, 1'b1, 8'd40, 1'b1);
        push_chk(8'd41, 1'b0, 8'd1, 1'b0);
        idle();

        // Reset while an output is held.
        do_reset();
        push_chk(8'd7, 1'b0, 8'd7, 1'b1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
        check("hold7_data", 32'(out_data), 7);
        rst_sys = 1'b1;
        step();
        check("midrst_valid", 32'(out_valid), 0);
        check("midrst_data", 32'(out_data), 0);
        check("midrst_first", 32'(out_first), 0);
        rst_sys   = 1'b0;
        out_ready = 1'b1;
        push_chk(8'd9, 1'b0, 8'd9, 1'b1);
        idle();

        // Randomized accumulated stream with random backpressure.
        do_reset();
        for (int i = 0; i < N_RND; i++) inc_arr[i] = diff_word_t'($urandom);
        rd_idx    = 0;
        rnd_phase = 1'b1;
        total     = '0;
        for (int i = 0; i < N_RND; i++) begin
            total = diff_word_t'(total + inc_arr[i]);
            if ($urandom_range(3) == 0) begin
                in_valid  = 1'b0;
                out_ready = 1'($urandom_range(1));
                step();
            end
            in_valid = 1'b1;
            in_data  = total;
            accepted = 1'b0;
            budget   = 0;
            while (!accepted && budget < 100) begin
                out_ready = 1'($urandom_range(1));
`ifdef ACC_DIFF_SKID_EN
                #1;
                r0 = in_ready;
                out_ready = ~out_ready;
                #1;
                check("ready_indep", 32'(in_ready), 32'(r0));
                out_ready = ~out_ready;
`endif
                @(negedge clk_sys);
                accepted = in_ready;
                @(posedge clk_sys);
                #1;
                budget++;
            end
            if (!accepted) check("accept_timeout", 0, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        budget    = 0;
        while (exp_q.size() != 0 && budget < 20) begin
            step();
            budget++;
        end
        check("rnd_drain", 32'(exp_q.size()), 0);
        check("rnd_count", 32'(rd_idx), 32'(N_RND));
        rnd_phase = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
